// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default baud divisor and bit-timer width.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int DELAY_FRAMES_DEF = 234;  // 27 MHz / 115200 baud
  localparam int CNT_W            = 13;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

  // Serial line level for a given state; anything unexpected idles high.
  function automatic logic line_level(input uart_state_e st, input logic data_bit,
                                      input logic par_bit);
    logic lvl;
    case (st)
      START:   lvl = 1'b0;
      DATA:    lvl = data_bit;
      PARITY:  lvl = par_bit;
      default: lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period counter: counts 1..DELAY_FRAMES and holds, flagging bit_done_o at the limit.
// Clear has priority over load, load over increment; shared by the TX and RX paths.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEF
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic load_i,
  input  logic clear_i,
  input  logic en_i,
  output logic bit_done_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DELAY_FRAMES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done_o = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (en_i && !bit_done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, one byte per valid/ready handshake, 8N1 (8E1 with UART_TX_PARITY_EN defined).
// Start bit on the line the cycle after the handshake; ready_o stays low until the frame ends.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEF
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       uart_tx_o,
  output logic       busy_o
);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, busy_q;
  logic        hs, bit_done, t_load, t_clear;
  logic        par_bit;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  assign par_bit = par_q;
`else
  assign par_bit = 1'b0;
`endif

  assign ready_o   = (state_q == IDLE) && reset_ni;
  assign hs        = valid_i && ready_o;
  assign uart_tx_o = tx_q;
  assign busy_o    = busy_q;

  uart_bit_timer #(
    .DELAY_FRAMES(DELAY_FRAMES)
  ) u_timer (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .load_i    (t_load),
    .clear_i   (t_clear),
    .en_i      (state_q != IDLE),
    .bit_done_o(bit_done)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    t_load    = 1'b0;
    t_clear   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = START;
          shift_d = data_i;
          t_load  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data_i;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          t_load    = 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = {1'b1, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          t_load    = 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          t_load  = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          t_clear = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        t_clear = 1'b1;
      end
    endcase
  end

  // Line is registered from next-state so every bit boundary is a single clean flop edge.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      shift_q   <= 8'hFF;
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= line_level(state_d, shift_d[0], par_bit);
      busy_q    <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule
